plot_request_arbiter: RTL and testbench
=======================================

// Module: plot_request_arbiter
// PURPOSE
//  Shares the single VGA plotter (newX/newY/oldX/oldY/sizeX/sizeY/object/startPlot)
//  among NUM_REQ independent drawing requesters (e.g. ball, paddle, brick eraser, overlay images).
//  Round-robin arbitration with a request/ack handshake.
//  Completion is plot_done from the plotter, replacing fixed per-object wait counts,
//  with a watchdog timeout as fallback.
//  Sits between the game logic requesters and the plotter.
// PARAMETERS
//  NUM_REQ         4       number of requesters; index 0 is granted first after reset
//  TIMEOUT_CYCLES  50000   max WAIT cycles before forced completion; counter width $clog2(TIMEOUT_CYCLES+1)
//  NO_OBJ          3'b011  object code driven when idle or in reset
// PORTS
//  clk        in   1            system clock; all logic on posedge
//  reset      in   1            synchronous, active-high reset
//  req        in   NUM_REQ      req[i]=1: requester i has a plot pending; held with data until ack[i]
//  req_newX   in   8*NUM_REQ    packed per-requester new X; slice i = [8*i+7:8*i]
//  req_newY   in   7*NUM_REQ    packed new Y
//  req_oldX   in   8*NUM_REQ    packed old X
//  req_oldY   in   7*NUM_REQ    packed old Y
//  req_sizeX  in   8*NUM_REQ    packed width
//  req_sizeY  in   7*NUM_REQ    packed height
//  req_object in   3*NUM_REQ    packed object code
//  plot_done  in   1            plotter finished current object; sampled only in WAIT
//  ack        out  NUM_REQ      one-cycle pulse to the granted requester when its command issues
//  newX,oldX  out  8            latched command to plotter
//  newY,oldY  out  7            latched command to plotter
//  sizeX      out  8            latched command to plotter
//  sizeY      out  7            latched command to plotter
//  object     out  3            latched command to plotter
//  startPlot  out  1            one-cycle start pulse to plotter
//  busy       out  1            high in ISSUE and WAIT
//  grant_id   out  $clog2(NUM_REQ)  index of the current or last granted requester
//  timeout_err out 1            sticky; set when a WAIT ends by timeout; cleared only by reset
// BEHAVIOUR
//  Reset (sync, dominates all other inputs):
//   - state=IDLE; all command outputs 0, object=NO_OBJ.
//   - startPlot=0, ack=0, busy=0, grant_id=0, timeout_err=0.
//   - RR pointer=NUM_REQ-1, wait counter=0.
//   - Reset mid-WAIT abandons the command; no ack and no startPlot follow.
//  FSM IDLE -> ISSUE -> WAIT -> IDLE.
//  IDLE:
//   - If any req bit is set, pick the first set bit searching ptr+1, ptr+2, ... modulo NUM_REQ.
//   - Latch its slices into the command outputs, set grant_id and ptr to it, go to ISSUE.
//   - If no req bit is set, stay; outputs keep their last values.
//  ISSUE (exactly 1 cycle): startPlot=1, ack[grant_id]=1, busy=1; counter cleared; go to WAIT.
//  WAIT:
//   - Command outputs are held stable; startPlot=0.
//   - Counter increments each cycle.
//   - plot_done=1 -> IDLE.
//   - Else if counter reaches TIMEOUT_CYCLES -> IDLE and timeout_err<=1.
//   - plot_done and timeout in the same cycle count as done; timeout_err is not set.
//  Latency:
//   - A req sampled in IDLE at cycle t gives startPlot/ack at t+1.
//   - plot_done at cycle d allows the next startPlot at d+2 at the earliest.
//  Requester rules:
//   - A req dropped before ack is simply not granted.
//   - req/data changes after the IDLE grant cycle do not affect the latched command.
//   - A req still high in the cycle after ack is treated as a new request.
//  Fairness: with all req continuously high, grants rotate 0,1,...,NUM_REQ-1,0,...
//  plot_done in IDLE or ISSUE is ignored.
// TESTING
//  T1 reset, then req=4'b0001, data {X=83,Y=112,sz=4x4,obj=000}:
//     -> startPlot and ack[0] one cycle after req; newX=83, newY=112, object=000;
//        busy until plot_done.
//  T2 req=4'b1111 held, plot_done 5 cycles after each start:
//     -> grant order 0,1,2,3,0; exactly one ack per grant.
//  T3 grant to 2, then change req_newX[2] during WAIT:
//     -> newX unchanged until the next grant.
//  T4 TIMEOUT_CYCLES=10, no plot_done:
//     -> returns to IDLE 10 cycles after entering WAIT; timeout_err=1 and stays 1
//        through later normal plots.
//  T5 reset asserted mid-WAIT with req=4'b0010:
//     -> next cycle all outputs at reset values, object=011;
//        after release requester 1 is granted first.
//  T6 plot_done in the same cycle as a new req[3]:
//     -> startPlot for requester 3 exactly two cycles after plot_done.

Source files
------------

// File: rtl/plot_request_arbiter.sv
// Round-robin arbiter that shares one VGA plotter among NUM_REQ drawing requesters.
// A command is latched on grant, issued for one cycle, then held until plot_done or a watchdog timeout.
module plot_request_arbiter #(
    parameter int          NUM_REQ        = 4,
    parameter int          TIMEOUT_CYCLES = 50000,
    parameter logic [2:0]  NO_OBJ         = 3'b011,
    localparam int         IDW            = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    localparam int         CW             = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [8*NUM_REQ-1:0] req_newX,
    input  logic [7*NUM_REQ-1:0] req_newY,
    input  logic [8*NUM_REQ-1:0] req_oldX,
    input  logic [7*NUM_REQ-1:0] req_oldY,
    input  logic [8*NUM_REQ-1:0] req_sizeX,
    input  logic [7*NUM_REQ-1:0] req_sizeY,
    input  logic [3*NUM_REQ-1:0] req_object,
    input  logic                 plot_done,
    output logic [NUM_REQ-1:0]   ack,
    output logic [7:0]           newX,
    output logic [6:0]           newY,
    output logic [7:0]           oldX,
    output logic [6:0]           oldY,
    output logic [7:0]           sizeX,
    output logic [6:0]           sizeY,
    output logic [2:0]           object,
    output logic                 startPlot,
    output logic                 busy,
    output logic [IDW-1:0]       grant_id,
    output logic                 timeout_err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT
    } state_t;

    state_t         state_q, state_d;
    logic [7:0]     newX_q, newX_d;
    logic [6:0]     newY_q, newY_d;
    logic [7:0]     oldX_q, oldX_d;
    logic [6:0]     oldY_q, oldY_d;
    logic [7:0]     sizeX_q, sizeX_d;
    logic [6:0]     sizeY_q, sizeY_d;
    logic [2:0]     object_q, object_d;
    logic [IDW-1:0] grantId_q, grantId_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [CW-1:0]  cntNext;
    logic           timeoutErr_q, timeoutErr_d;
    logic           pickValid;
    logic [IDW-1:0] pickIdx;

    function automatic logic [IDW-1:0] rrIndex(input logic [IDW-1:0] base, input int k);
        return IDW'((int'(base) + k) % NUM_REQ);
    endfunction

    // Scanning from the farthest candidate down lets the nearest requester after ptr win.
    always_comb begin
        pickValid = 1'b0;
        pickIdx   = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            if (req[rrIndex(ptr_q, k)]) begin
                pickValid = 1'b1;
                pickIdx   = rrIndex(ptr_q, k);
            end
        end
    end

    assign cntNext = cnt_q + CW'(1);

    always_comb begin
        state_d      = state_q;
        newX_d       = newX_q;
        newY_d       = newY_q;
        oldX_d       = oldX_q;
        oldY_d       = oldY_q;
        sizeX_d      = sizeX_q;
        sizeY_d      = sizeY_q;
        object_d     = object_q;
        grantId_d    = grantId_q;
        ptr_d        = ptr_q;
        cnt_d        = cnt_q;
        timeoutErr_d = timeoutErr_q;
        case (state_q)
            S_IDLE: begin
                if (pickValid) begin
                    newX_d    = req_newX[8*pickIdx +: 8];
                    newY_d    = req_newY[7*pickIdx +: 7];
                    oldX_d    = req_oldX[8*pickIdx +: 8];
                    oldY_d    = req_oldY[7*pickIdx +: 7];
                    sizeX_d   = req_sizeX[8*pickIdx +: 8];
                    sizeY_d   = req_sizeY[7*pickIdx +: 7];
                    object_d  = req_object[3*pickIdx +: 3];
                    grantId_d = pickIdx;
                    ptr_d     = pickIdx;
                    state_d   = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                cnt_d = cntNext;
                // A plot_done coinciding with the timeout wins and leaves the error flag alone.
                if (plot_done) begin
                    state_d = S_IDLE;
                end else if (cntNext == CW'(TIMEOUT_CYCLES)) begin
                    state_d      = S_IDLE;
                    timeoutErr_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            newX_q       <= '0;
            newY_q       <= '0;
            oldX_q       <= '0;
            oldY_q       <= '0;
            sizeX_q      <= '0;
            sizeY_q      <= '0;
            object_q     <= NO_OBJ;
            grantId_q    <= '0;
            ptr_q        <= IDW'(NUM_REQ - 1);
            cnt_q        <= '0;
            timeoutErr_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            newX_q       <= newX_d;
            newY_q       <= newY_d;
            oldX_q       <= oldX_d;
            oldY_q       <= oldY_d;
            sizeX_q      <= sizeX_d;
            sizeY_q      <= sizeY_d;
            object_q     <= object_d;
            grantId_q    <= grantId_d;
            ptr_q        <= ptr_d;
            cnt_q        <= cnt_d;
            timeoutErr_q <= timeoutErr_d;
        end
    end

    always_comb begin
        ack = '0;
        if (state_q == S_ISSUE) begin
            ack[grantId_q] = 1'b1;
        end
    end

    assign startPlot   = (state_q == S_ISSUE);
    assign busy        = (state_q != S_IDLE);
    assign newX        = newX_q;
    assign newY        = newY_q;
    assign oldX        = oldX_q;
    assign oldY        = oldY_q;
    assign sizeX       = sizeX_q;
    assign sizeY       = sizeY_q;
    assign object      = object_q;
    assign grant_id    = grantId_q;
    assign timeout_err = timeoutErr_q;

endmodule

// File: tb/tb_plot_request_arbiter.sv
// Self-checking bench for plot_request_arbiter with a command scoreboard and a round-robin reference pointer.
module tb_plot_request_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [31:0] req_newX, req_oldX, req_sizeX;
    logic [27:0] req_newY, req_oldY, req_sizeY;
    logic [11:0] req_object;
    logic        plot_done;
    logic [3:0]  ack;
    logic [7:0]  newX, oldX, sizeX;
    logic [6:0]  newY, oldY, sizeY;
    logic [2:0]  object;
    logic        startPlot, busy, timeout_err;
    logic [1:0]  grant_id;

    logic [7:0] dNewX [4];
    logic [6:0] dNewY [4];
    logic [7:0] dOldX [4];
    logic [6:0] dOldY [4];
    logic [7:0] dSizeX [4];
    logic [6:0] dSizeY [4];
    logic [2:0] dObj [4];

    logic [49:0] expQ [$];
    logic [49:0] expCmd;
    logic [49:0] obsCmd;
    int          vecCount = 0;
    int          missCount = 0;
    int          ackCount = 0;
    int          modelPtr = 3;

    plot_request_arbiter #(.NUM_REQ(4), .TIMEOUT_CYCLES(10), .NO_OBJ(3'b011)) dut (
        .clk(clk), .reset(reset), .req(req),
        .req_newX(req_newX), .req_newY(req_newY), .req_oldX(req_oldX), .req_oldY(req_oldY),
        .req_sizeX(req_sizeX), .req_sizeY(req_sizeY), .req_object(req_object),
        .plot_done(plot_done), .ack(ack),
        .newX(newX), .newY(newY), .oldX(oldX), .oldY(oldY),
        .sizeX(sizeX), .sizeY(sizeY), .object(object),
        .startPlot(startPlot), .busy(busy), .grant_id(grant_id), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    assign req_newX   = {dNewX[3], dNewX[2], dNewX[1], dNewX[0]};
    assign req_newY   = {dNewY[3], dNewY[2], dNewY[1], dNewY[0]};
    assign req_oldX   = {dOldX[3], dOldX[2], dOldX[1], dOldX[0]};
    assign req_oldY   = {dOldY[3], dOldY[2], dOldY[1], dOldY[0]};
    assign req_sizeX  = {dSizeX[3], dSizeX[2], dSizeX[1], dSizeX[0]};
    assign req_sizeY  = {dSizeY[3], dSizeY[2], dSizeY[1], dSizeY[0]};
    assign req_object = {dObj[3], dObj[2], dObj[1], dObj[0]};
    assign obsCmd     = {grant_id, newX, newY, oldX, oldY, sizeX, sizeY, object};

    always @(negedge clk) ackCount = ackCount + $countones(ack);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [49:0] cmdOf(input int id);
        logic [1:0] idBits;
        idBits = 2'(id);
        return {idBits, dNewX[id], dNewY[id], dOldX[id], dOldY[id], dSizeX[id], dSizeY[id], dObj[id]};
    endfunction

    // Reference round-robin: first set bit after the last grant, wrapping.
    function automatic int modelPick(input logic [3:0] r);
        for (int k = 1; k <= 4; k++) begin
            if (r[(modelPtr + k) % 4]) return (modelPtr + k) % 4;
        end
        return -1;
    endfunction

    task automatic expectGrant(input logic [3:0] r);
        int id;
        id = modelPick(r);
        modelPtr = id;
        expQ.push_back(cmdOf(id));
    endtask

    task automatic waitStart(input int maxCycles, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < maxCycles; i++) begin
            tick();
            if (startPlot === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic finishPlot(input int delay);
        for (int i = 0; i < delay; i++) tick();
        plot_done = 1'b1;
        tick();
        plot_done = 1'b0;
    endtask

    task automatic test_reset();
        logic [54:0] obs, exp;
        reset = 1'b1;
        req = 4'b1111;
        tick();
        obs = {startPlot, ack, busy, timeout_err, obsCmd};
        exp = {1'b0, 4'b0000, 1'b0, 1'b0, 2'd0, 8'd0, 7'd0, 8'd0, 7'd0, 8'd0, 7'd0, 3'b011};
        vecCount++;
        if (obs !== exp) begin
            missCount++;
            $display("[TB] FAIL reset_state: got %h expected %h", obs, exp);
        end
        req = 4'b0000;
        reset = 1'b0;
        modelPtr = 3;
    endtask

    task automatic test_single();
        dNewX[0] = 8'd83; dNewY[0] = 7'd112; dSizeX[0] = 8'd4; dSizeY[0] = 7'd4; dObj[0] = 3'b000;
        req = 4'b0001;
        expectGrant(req);
        tick();
        vecCount++;
        if ({startPlot, ack} !== {1'b1, 4'b0001}) begin
            missCount++;
            $display("[TB] FAIL single_latency: got %b expected %b", {startPlot, ack}, {1'b1, 4'b0001});
        end
        expCmd = expQ.pop_front();
        vecCount++;
        if (obsCmd !== expCmd) begin
            missCount++;
            $display("[TB] FAIL single_cmd: got %h expected %h", obsCmd, expCmd);
        end
        req = 4'b0000;
        for (int i = 0; i < 3; i++) tick();
        vecCount++;
        if ({busy, startPlot, ack} !== {1'b1, 1'b0, 4'b0000}) begin
            missCount++;
            $display("[TB] FAIL single_wait: got %b expected %b", {busy, startPlot, ack}, 6'b100000);
        end
        finishPlot(0);
        vecCount++;
        if (busy !== 1'b0) begin
            missCount++;
            $display("[TB] FAIL single_done: got busy=%b expected 0", busy);
        end
    endtask

    task automatic test_round_robin();
        bit seen;
        int ackBefore;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        modelPtr = 3;
        req = 4'b1111;
        for (int i = 0; i < 5; i++) expectGrant(req);
        ackBefore = ackCount;
        for (int i = 0; i < 5; i++) begin
            waitStart(20, seen);
            expCmd = expQ.pop_front();
            vecCount++;
            if (!seen || ack !== (4'b0001 << expCmd[49:48])) begin
                missCount++;
                $display("[TB] FAIL rr_ack%0d: got seen=%b ack=%b expected ack=%b", i, seen, ack,
                         4'b0001 << expCmd[49:48]);
            end
            vecCount++;
            if (obsCmd !== expCmd) begin
                missCount++;
                $display("[TB] FAIL rr_cmd%0d: got %h expected %h", i, obsCmd, expCmd);
            end
            if (i == 4) req = 4'b0000;
            finishPlot(4);
        end
        tick();
        vecCount++;
        if (ackCount - ackBefore !== 5) begin
            missCount++;
            $display("[TB] FAIL rr_ack_count: got %0d expected 5", ackCount - ackBefore);
        end
    endtask

    task automatic test_hold_data();
        bit seen;
        logic [7:0] savedX;
        req = 4'b0100;
        expectGrant(req);
        waitStart(20, seen);
        expCmd = expQ.pop_front();
        savedX = expCmd[47:40];
        vecCount++;
        if (!seen || obsCmd !== expCmd) begin
            missCount++;
            $display("[TB] FAIL hold_grant: got seen=%b cmd=%h expected %h", seen, obsCmd, expCmd);
        end
        req = 4'b0000;
        dNewX[2] = 8'hEE;
        for (int i = 0; i < 3; i++) tick();
        vecCount++;
        if (newX !== savedX) begin
            missCount++;
            $display("[TB] FAIL hold_wait_newX: got %h expected %h", newX, savedX);
        end
        finishPlot(0);
        tick();
        vecCount++;
        if (newX !== savedX) begin
            missCount++;
            $display("[TB] FAIL hold_idle_newX: got %h expected %h", newX, savedX);
        end
        req = 4'b0100;
        expectGrant(req);
        waitStart(20, seen);
        expCmd = expQ.pop_front();
        vecCount++;
        if (!seen || obsCmd !== expCmd) begin
            missCount++;
            $display("[TB] FAIL hold_regrant: got seen=%b cmd=%h expected %h", seen, obsCmd, expCmd);
        end
        req = 4'b0000;
        finishPlot(2);
    endtask

    task automatic test_timeout();
        bit seen;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        modelPtr = 3;
        // plot_done lands in the very cycle the watchdog would expire
        req = 4'b0010;
        expectGrant(req);
        waitStart(20, seen);
        expCmd = expQ.pop_front();
        vecCount++;
        if (!seen || obsCmd !== expCmd) begin
            missCount++;
            $display("[TB] FAIL to_grant_a: got seen=%b cmd=%h expected %h", seen, obsCmd, expCmd);
        end
        req = 4'b0000;
        for (int i = 0; i < 10; i++) tick();
        plot_done = 1'b1;
        tick();
        plot_done = 1'b0;
        vecCount++;
        if ({busy, timeout_err} !== 2'b00) begin
            missCount++;
            $display("[TB] FAIL to_coincident: got busy/err=%b expected 00", {busy, timeout_err});
        end
        req = 4'b0010;
        expectGrant(req);
        waitStart(20, seen);
        expCmd = expQ.pop_front();
        vecCount++;
        if (!seen || obsCmd !== expCmd) begin
            missCount++;
            $display("[TB] FAIL to_grant_b: got seen=%b cmd=%h expected %h", seen, obsCmd, expCmd);
        end
        req = 4'b0000;
        for (int i = 0; i < 10; i++) tick();
        vecCount++;
        if ({busy, timeout_err} !== 2'b10) begin
            missCount++;
            $display("[TB] FAIL to_before_expiry: got busy/err=%b expected 10", {busy, timeout_err});
        end
        tick();
        vecCount++;
        if ({busy, timeout_err} !== 2'b01) begin
            missCount++;
            $display("[TB] FAIL to_expired: got busy/err=%b expected 01", {busy, timeout_err});
        end
        req = 4'b1000;
        expectGrant(req);
        waitStart(20, seen);
        expCmd = expQ.pop_front();
        vecCount++;
        if (!seen || obsCmd !== expCmd) begin
            missCount++;
            $display("[TB] FAIL to_grant_c: got seen=%b cmd=%h expected %h", seen, obsCmd, expCmd);
        end
        req = 4'b0000;
        finishPlot(2);
        vecCount++;
        if ({busy, timeout_err} !== 2'b01) begin
            missCount++;
            $display("[TB] FAIL to_sticky: got busy/err=%b expected 01", {busy, timeout_err});
        end
    endtask

    task automatic test_reset_mid_wait();
        bit seen;
        logic [54:0] obs, exp;
        req = 4'b0010;
        expectGrant(req);
        waitStart(20, seen);
        expCmd = expQ.pop_front();
        vecCount++;
        if (!seen || obsCmd !== expCmd) begin
            missCount++;
            $display("[TB] FAIL rst_grant: got seen=%b cmd=%h expected %h", seen, obsCmd, expCmd);
        end
        tick();
        tick();
        reset = 1'b1;
        req = 4'b1010;
        tick();
        obs = {startPlot, ack, busy, timeout_err, obsCmd};
        exp = {1'b0, 4'b0000, 1'b0, 1'b0, 2'd0, 8'd0, 7'd0, 8'd0, 7'd0, 8'd0, 7'd0, 3'b011};
        vecCount++;
        if (obs !== exp) begin
            missCount++;
            $display("[TB] FAIL rst_mid_wait: got %h expected %h", obs, exp);
        end
        reset = 1'b0;
        modelPtr = 3;
        expectGrant(req);
        tick();
        vecCount++;
        if ({startPlot, ack} !== {1'b1, 4'b0010}) begin
            missCount++;
            $display("[TB] FAIL rst_first_grant: got %b expected %b", {startPlot, ack}, 5'b10010);
        end
        expCmd = expQ.pop_front();
        vecCount++;
        if (obsCmd !== expCmd) begin
            missCount++;
            $display("[TB] FAIL rst_cmd: got %h expected %h", obsCmd, expCmd);
        end
        req = 4'b0000;
        finishPlot(2);
    endtask

    task automatic test_back_to_back();
        bit seen;
        req = 4'b0001;
        expectGrant(req);
        waitStart(20, seen);
        expCmd = expQ.pop_front();
        vecCount++;
        if (!seen || obsCmd !== expCmd) begin
            missCount++;
            $display("[TB] FAIL b2b_grant: got seen=%b cmd=%h expected %h", seen, obsCmd, expCmd);
        end
        req = 4'b0000;
        for (int i = 0; i < 3; i++) tick();
        plot_done = 1'b1;
        req = 4'b1000;
        expectGrant(req);
        tick();
        plot_done = 1'b0;
        vecCount++;
        if ({startPlot, busy} !== 2'b00) begin
            missCount++;
            $display("[TB] FAIL b2b_gap: got start/busy=%b expected 00", {startPlot, busy});
        end
        tick();
        vecCount++;
        if ({startPlot, ack} !== {1'b1, 4'b1000}) begin
            missCount++;
            $display("[TB] FAIL b2b_start: got %b expected %b", {startPlot, ack}, 5'b11000);
        end
        expCmd = expQ.pop_front();
        vecCount++;
        if (obsCmd !== expCmd) begin
            missCount++;
            $display("[TB] FAIL b2b_cmd: got %h expected %h", obsCmd, expCmd);
        end
        req = 4'b0000;
        finishPlot(2);
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            dNewX[i]  = 8'(20 + 40 * i);
            dNewY[i]  = 7'(10 + 25 * i);
            dOldX[i]  = 8'(5 + 30 * i);
            dOldY[i]  = 7'(3 + 20 * i);
            dSizeX[i] = 8'(4 + i);
            dSizeY[i] = 7'(4 + 2 * i);
            dObj[i]   = 3'(2 * i);
        end
        reset = 1'b1;
        req = 4'b0000;
        plot_done = 1'b0;
        tick();
        test_reset();
        test_single();
        test_round_robin();
        test_hold_data();
        test_timeout();
        test_reset_mid_wait();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
